// File: rtl/dmem_bridge.sv
// Stage-M data-memory responder: one request/response memory transaction per CPU access.
// Latency: store 2 stall cycles, load 3, misaligned 1; each ready/response wait cycle adds one.
// Backpressure: request held stable until mem_req_ready; pipeline stalled until the access completes.
module dmem_bridge #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [31:0]           cpu_wdata,
    input  logic [3:0]            cpu_we,
    input  logic                  cpu_re,
    input  logic [1:0]            cpu_st_size,
    input  logic [2:0]            cpu_ld_size,
    output logic [31:0]           cpu_rdata,
    output logic                  cpu_stall,
    output logic                  cpu_misalign,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_rw,
    output logic [ADDR_WIDTH-3:0] mem_req_addr,
    output logic [31:0]           mem_req_wdata,
    output logic [3:0]            mem_req_wmask,
    input  logic                  mem_resp_valid,
    input  logic [31:0]           mem_resp_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] ST_B = 2'b00;
    localparam logic [1:0] ST_H = 2'b01;

    localparam logic [2:0] LD_B  = 3'b000;
    localparam logic [2:0] LD_H  = 3'b001;
    localparam logic [2:0] LD_W  = 3'b010;
    localparam logic [2:0] LD_BU = 3'b100;
    localparam logic [2:0] LD_HU = 3'b101;

    logic [1:0] state;
    logic [1:0] off_q;
    logic [2:0] ld_size_q;

    logic       is_st;
    logic       op;
    logic [1:0] off;
    logic       mis_st;
    logic       mis_ld;
    logic       misaligned;
    logic [3:0] st_mask;
    logic [31:0] st_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    // A store wins when both a store and a load are presented together.
    assign is_st = |cpu_we;
    assign op    = cpu_re | is_st;
    assign off   = cpu_addr[1:0];

    assign mis_st     = ((cpu_st_size == ST_H) && off[0]) || (cpu_st_size[1] && (off != 2'b00));
    assign mis_ld     = ((cpu_ld_size[1:0] == 2'b01) && off[0]) || ((cpu_ld_size == LD_W) && (off != 2'b00));
    assign misaligned = is_st ? mis_st : mis_ld;

    always_comb begin
        st_mask = 4'b1111;
        st_data = cpu_wdata;
        case (cpu_st_size)
            ST_B: begin
                st_mask = 4'b0001 << off;
                st_data = {4{cpu_wdata[7:0]}};
            end
            ST_H: begin
                st_mask = 4'b0011 << {off[1], 1'b0};
                st_data = {2{cpu_wdata[15:0]}};
            end
            default: begin
                st_mask = 4'b1111;
                st_data = cpu_wdata;
            end
        endcase
    end

    always_comb begin
        ld_byte = mem_resp_data[7:0];
        case (off_q)
            2'd0:    ld_byte = mem_resp_data[7:0];
            2'd1:    ld_byte = mem_resp_data[15:8];
            2'd2:    ld_byte = mem_resp_data[23:16];
            default: ld_byte = mem_resp_data[31:24];
        endcase
        ld_half = off_q[1] ? mem_resp_data[31:16] : mem_resp_data[15:0];
    end

    always_comb begin
        ld_ext = 32'd0;
        case (ld_size_q)
            LD_B:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
            LD_H:    ld_ext = {{16{ld_half[15]}}, ld_half};
            LD_W:    ld_ext = mem_resp_data;
            LD_BU:   ld_ext = {24'd0, ld_byte};
            LD_HU:   ld_ext = {16'd0, ld_half};
            default: ld_ext = 32'd0;
        endcase
    end

    assign cpu_stall = ((state == S_IDLE) && op) || (state == S_REQ) || (state == S_WAIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            off_q         <= 2'd0;
            ld_size_q     <= 3'd0;
            cpu_rdata     <= 32'd0;
            cpu_misalign  <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_rw    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= 32'd0;
            mem_req_wmask <= 4'd0;
        end else begin
            cpu_misalign <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (op) begin
                        if (misaligned) begin
                            cpu_misalign <= 1'b1;
                            state        <= S_DONE;
                        end else begin
                            mem_req_addr  <= cpu_addr[ADDR_WIDTH-1:2];
                            off_q         <= off;
                            mem_req_rw    <= is_st;
                            ld_size_q     <= cpu_ld_size;
                            mem_req_wmask <= is_st ? st_mask : 4'd0;
                            mem_req_wdata <= st_data;
                            mem_req_valid <= 1'b1;
                            state         <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= mem_req_rw ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        cpu_rdata <= ld_ext;
                        state     <= S_DONE;
                    end
                end
                default: begin
                    // One unstalled cycle; inputs are ignored so a held request is not re-issued here.
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// Bench for dmem_bridge: directed scenarios plus random accesses against a byte-level memory model.
module tb_dmem_bridge;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] cpu_addr;
    logic [31:0]   cpu_wdata;
    logic [3:0]    cpu_we;
    logic          cpu_re;
    logic [1:0]    cpu_st_size;
    logic [2:0]    cpu_ld_size;
    logic [31:0]   cpu_rdata;
    logic          cpu_stall;
    logic          cpu_misalign;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic          mem_req_rw;
    logic [AW-3:0] mem_req_addr;
    logic [31:0]   mem_req_wdata;
    logic [3:0]    mem_req_wmask;
    logic          mem_resp_valid;
    logic [31:0]   mem_resp_data;

    int errors = 0;
    int checks = 0;
    logic [31:0] mem [64];
    logic [31:0] exp_rdata;

    dmem_bridge #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_re(cpu_re),
        .cpu_st_size(cpu_st_size), .cpu_ld_size(cpu_ld_size),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_misalign(cpu_misalign),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int access_bytes(input bit is_st, input logic [1:0] st, input logic [2:0] ld);
        if (is_st) return (st == 2'd0) ? 1 : (st == 2'd1) ? 2 : 4;
        if (ld == 3'd2) return 4;
        if (ld == 3'd1 || ld == 3'd5) return 2;
        return 1;
    endfunction

    function automatic logic [31:0] load_model(input logic [31:0] word, input int off, input logic [2:0] ld);
        logic [31:0] b;
        logic [31:0] h;
        b = (word >> (8 * off)) & 32'hFF;
        h = (word >> (16 * (off / 2))) & 32'hFFFF;
        case (ld)
            3'd0: return (b >= 32'd128) ? b - 32'd256 : b;
            3'd1: return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd2: return word;
            3'd4: return b;
            3'd5: return h;
            default: return 32'd0;
        endcase
    endfunction

    task automatic clear_inputs();
        cpu_addr = '0; cpu_wdata = '0; cpu_we = '0; cpu_re = 1'b0;
        cpu_st_size = '0; cpu_ld_size = '0;
    endtask

    task automatic access(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] we, input logic re, input logic [1:0] st,
                          input logic [2:0] ld, input int rdly, input int sdly);
        bit          is_st;
        bit          mis;
        bit          done;
        bit          accepted;
        int          off;
        int          size;
        int          idx;
        int          stall_n;
        int          vld_n;
        int          wait_n;
        int          exp_stall;
        logic [31:0] exp_wd;
        logic [3:0]  exp_wm;

        is_st    = (we != 4'd0);
        off      = int'(addr[1:0]);
        idx      = int'(addr[7:2]);
        size     = access_bytes(is_st, st, ld);
        mis      = (off % size) != 0;
        done     = 1'b0;
        accepted = 1'b0;
        stall_n  = 0;
        vld_n    = 0;
        wait_n   = 0;
        exp_wd   = '0;
        exp_wm   = '0;
        for (int l = 0; l < 4; l++) begin
            exp_wd[8*l +: 8] = wd[8*(l % size) +: 8];
            exp_wm[l]        = is_st && (l >= off) && (l < off + size);
        end
        if (mis) exp_stall = 1;
        else if (is_st) exp_stall = 1 + (rdly + 1);
        else exp_stall = 1 + (rdly + 1) + sdly;
        if (!mis && !is_st) exp_rdata = load_model(mem[idx], off, ld);

        @(negedge clk);
        cpu_addr = addr; cpu_wdata = wd; cpu_we = we; cpu_re = re;
        cpu_st_size = st; cpu_ld_size = ld;
        for (int c = 0; c < 64 && !done; c++) begin
            if (c > 0) @(negedge clk);
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            mem_resp_data  = $urandom;
            #1;
            if (c == 0) chk({tag, "_idle_misalign"}, 32'(cpu_misalign), 32'd0);
            if (cpu_stall !== 1'b1) begin
                done = 1'b1;
            end else begin
                stall_n++;
                if (mem_req_valid === 1'b1) begin
                    vld_n++;
                    if (vld_n > rdly) begin
                        chk({tag, "_addr"}, 32'(mem_req_addr), 32'(addr[31:2]));
                        chk({tag, "_rw"}, 32'(mem_req_rw), 32'(is_st));
                        chk({tag, "_wmask"}, 32'(mem_req_wmask), 32'(exp_wm));
                        if (is_st) chk({tag, "_wdata"}, mem_req_wdata, exp_wd);
                        mem_req_ready = 1'b1;
                        accepted      = 1'b1;
                    end else begin
                        mem_resp_valid = 1'b1;  // stray response while the request is pending
                    end
                end else if (accepted) begin
                    wait_n++;
                    if (wait_n == sdly) begin
                        mem_resp_valid = 1'b1;
                        mem_resp_data  = mem[idx];
                    end
                end else begin
                    mem_resp_valid = 1'b1;  // stray response in IDLE
                end
            end
        end
        chk({tag, "_completed"}, 32'(done), 32'd1);
        chk({tag, "_stall_cycles"}, 32'(stall_n), 32'(exp_stall));
        chk({tag, "_valid_cycles"}, 32'(vld_n), mis ? 32'd0 : 32'(rdly + 1));
        chk({tag, "_done_misalign"}, 32'(cpu_misalign), 32'(mis));
        chk({tag, "_done_valid"}, 32'(mem_req_valid), 32'd0);
        chk({tag, "_rdata"}, cpu_rdata, exp_rdata);
        if (is_st && !mis) begin
            for (int i = 0; i < size; i++) mem[idx][8*(off+i) +: 8] = wd[8*i +: 8];
        end
    endtask

    initial begin
        logic [2:0] ld_tab [5];
        int         kind;
        logic [31:0] a;

        ld_tab[0] = 3'd0; ld_tab[1] = 3'd1; ld_tab[2] = 3'd2; ld_tab[3] = 3'd4; ld_tab[4] = 3'd5;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        exp_rdata = 32'd0;
        reset = 1'b0;
        clear_inputs();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk("rst_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_rw", 32'(mem_req_rw), 32'd0);
        chk("rst_addr", 32'(mem_req_addr), 32'd0);
        chk("rst_wdata", mem_req_wdata, 32'd0);
        chk("rst_wmask", 32'(mem_req_wmask), 32'd0);
        chk("rst_misalign", 32'(cpu_misalign), 32'd0);
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Directed scenarios
        access("sb_1003", 32'h1003, 32'h0000_00AB, 4'b1000, 1'b0, 2'd0, 3'd0, 0, 1);
        chk("sb_1003_addr_const", 32'(mem_req_addr), 32'h400);
        chk("sb_1003_wdata_const", mem_req_wdata, 32'hABAB_ABAB);
        chk("sb_1003_wmask_const", 32'(mem_req_wmask), 32'h8);
        mem[0] = 32'h8001_1234;
        access("lh_2002", 32'h2002, 32'h0, 4'd0, 1'b1, 2'd0, 3'd1, 0, 1);
        chk("lh_2002_const", cpu_rdata, 32'hFFFF_8001);
        access("lhu_2002", 32'h2002, 32'h0, 4'd0, 1'b1, 2'd0, 3'd5, 0, 1);
        chk("lhu_2002_const", cpu_rdata, 32'h0000_8001);
        mem[4] = 32'h1357_9BDF;
        access("lw_10", 32'h10, 32'h0, 4'd0, 1'b1, 2'd0, 3'd2, 3, 2);
        chk("lw_10_const", cpu_rdata, 32'h1357_9BDF);
        access("sw_6_mis", 32'h6, 32'hCAFE_F00D, 4'b1111, 1'b0, 2'd2, 3'd0, 0, 1);
        chk("sw_6_rdata_const", cpu_rdata, 32'h1357_9BDF);
        access("sb_25", 32'h25, 32'h0000_007F, 4'b0010, 1'b0, 2'd0, 3'd0, 1, 1);
        access("lbu_25", 32'h25, 32'h0, 4'd0, 1'b1, 2'd0, 3'd4, 0, 1);
        chk("lbu_25_const", cpu_rdata, 32'h0000_007F);
        access("st_and_ld", 32'h30, 32'h0102_0304, 4'b1111, 1'b1, 2'd2, 3'd2, 2, 1);
        access("lw_30", 32'h30, 32'h0, 4'd0, 1'b1, 2'd0, 3'd2, 0, 3);
        chk("lw_30_const", cpu_rdata, 32'h0102_0304);

        // Reset while a store request is pending
        @(negedge clk);
        cpu_addr = 32'h40; cpu_wdata = 32'h5555_AAAA; cpu_we = 4'hF; cpu_st_size = 2'd2;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        @(negedge clk); #1;
        chk("req_before_rst_valid", 32'(mem_req_valid), 32'd1);
        reset = 1'b0; #1;
        chk("rst_in_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_in_req_stall_op", 32'(cpu_stall), 32'd1);
        clear_inputs(); #1;
        chk("rst_in_req_stall_idle", 32'(cpu_stall), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Reset during WAIT, then a late response
        @(negedge clk);
        cpu_addr = 32'h20; cpu_re = 1'b1; cpu_ld_size = 3'd2;
        @(negedge clk); #1;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0; #1;
        chk("wait_before_rst_stall", 32'(cpu_stall), 32'd1);
        reset = 1'b0; #1;
        clear_inputs(); #1;
        chk("rst_in_wait_stall", 32'(cpu_stall), 32'd0);
        chk("rst_in_wait_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_in_wait_rdata", cpu_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        mem_resp_valid = 1'b0; #1;
        chk("late_resp_rdata", cpu_rdata, 32'd0);
        chk("late_resp_valid", 32'(mem_req_valid), 32'd0);
        chk("late_resp_stall", 32'(cpu_stall), 32'd0);
        exp_rdata = 32'd0;

        // Random accesses
        for (int n = 0; n < 120; n++) begin
            kind = $urandom_range(0, 7);
            a = $urandom & 32'h0000_3FFF;
            if (kind < 3) begin
                access("rnd_st", a, $urandom, 4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)),
                       2'(kind), 3'd0, $urandom_range(0, 3), 1);
            end else begin
                access("rnd_ld", a, $urandom, 4'd0, 1'b1, 2'd0, ld_tab[$urandom_range(0, 4)],
                       $urandom_range(0, 3), $urandom_range(1, 3));
            end
        end

        @(negedge clk);
        clear_inputs();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
